fft_np_control: RTL

- Parametrised N-point (N = 2^LOG2N) radix-2 FFT pipeline controller; the next generation of the fixed 8-point controller.
- Counts input samples into the serial-to-parallel register and fires one enable per butterfly stage as each frame advances through the stages.
- Flags frame completion; tracks forward/inverse mode per frame.
- Sits between the sample source and the S2P/butterfly datapath.
- Adds explicit start/stop, input-valid stalling, graceful drain, and a per-frame inverse flag.

---
 rtl/fft_ctrl_pkg.sv | 13 +
 rtl/fft_np_control_if.sv | 55 +++++
 rtl/fft_ctrl_stage_pipe.sv | 46 ++++
 rtl/fft_np_control.sv | 116 +++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the N-point FFT pipeline controller.
package fft_ctrl_pkg;

  localparam int FFT_MAX_LOG2N = 10;
  localparam int FFT_DEF_LOG2N = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fft_state_e;

endpackage

// File: rtl/fft_np_control_if.sv
// Sample-side and datapath-side signals of the FFT controller.
// frame_cnt exists only when FFT_CTRL_STATS_EN is defined.
//
// Handshake: in_valid is offered by the source; en_s2p is the accept. A sample
// transfers in exactly the cycles where en_s2p is high (en_s2p = in_valid while
// running). There is no backpressure beyond that: when en_s2p is low with
// in_valid high the source must hold the sample and retry.
interface fft_np_control_if
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N = FFT_DEF_LOG2N,
  parameter int CNT_W = 16
);

  logic             start;
  logic             stop;
  logic             inverse_i;
  logic             in_valid;
  logic             en_s2p;
  logic [LOG2N-1:0] sample_idx;
  logic             frame_last;
  logic [LOG2N-1:0] en_stage;
  logic [LOG2N-1:0] inv_stage;
  logic             out_valid;
  logic             out_inverse;
  logic             busy;
  fft_state_e       dbg_state;
`ifdef FFT_CTRL_STATS_EN
  logic [CNT_W-1:0] frame_cnt;
`endif

  // Reject widths that cannot describe a real controller.
  if (LOG2N < 1 || LOG2N > FFT_MAX_LOG2N || CNT_W < 1) begin : g_bad_width
    $error("fft_np_control_if: illegal LOG2N or CNT_W");
  end

  modport master (
    output start, stop, inverse_i, in_valid,
    input  en_s2p, sample_idx, frame_last, en_stage, inv_stage,
    input  out_valid, out_inverse, busy, dbg_state
`ifdef FFT_CTRL_STATS_EN
    , input frame_cnt
`endif
  );

  modport slave (
    input  start, stop, inverse_i, in_valid,
    output en_s2p, sample_idx, frame_last, en_stage, inv_stage,
    output out_valid, out_inverse, busy, dbg_state
`ifdef FFT_CTRL_STATS_EN
    , output frame_cnt
`endif
  );

endinterface

// File: rtl/fft_ctrl_stage_pipe.sv
// LOG2N+1 deep valid/inverse shift pipe: entry s marks the frame currently in
// butterfly stage s; the last entry marks the finished result.
module fft_ctrl_stage_pipe #(
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             load_inv_i,
  output logic [LOG2N-1:0] en_stage_o,
  output logic [LOG2N-1:0] inv_stage_o,
  output logic             out_valid_o,
  output logic             out_inverse_o,
  output logic             pipe_empty_o
);

  logic [LOG2N:0] valid_q, valid_d;
  logic [LOG2N:0] inv_q, inv_d;

  // Advance every frame one stage per cycle; the inverse bit is only ever set
  // alongside a valid bit so idle entries read as zero.
  always_comb begin
    valid_d = {valid_q[LOG2N-1:0], load_i};
    inv_d   = {inv_q[LOG2N-1:0], load_i & load_inv_i};
  end

  // Pipe registers; reset discards any in-flight frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      inv_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inv_q   <= inv_d;
    end
  end

  assign en_stage_o    = valid_q[LOG2N-1:0];
  assign inv_stage_o   = inv_q[LOG2N-1:0];
  assign out_valid_o   = valid_q[LOG2N];
  assign out_inverse_o = inv_q[LOG2N];
  // Nothing survives past this cycle: only the output entry (if any) is live
  // and no new frame is entering.
  assign pipe_empty_o  = ~(|valid_q[LOG2N-1:0]) & ~load_i;

endmodule

// File: rtl/fft_np_control.sv
// N-point (N = 2^LOG2N) radix-2 FFT pipeline controller: counts samples into
// the S2P register, walks each frame through the butterfly stages and flags
// completion with the frame's forward/inverse mode.
// Optional frame statistics counter: define FFT_CTRL_STATS_EN.
module fft_np_control
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N = FFT_DEF_LOG2N,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  fft_np_control_if.slave  bus
);

  localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

  if (LOG2N < 1 || LOG2N > FFT_MAX_LOG2N || CNT_W < 1) begin : g_bad_param
    $error("fft_np_control: illegal LOG2N or CNT_W");
  end

  fft_state_e       state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic             inv_frame_q, inv_frame_d;
  logic             accept;
  logic             last;
  logic             stop_req;
  logic             pipe_empty;

  // Next-state logic. A stop request (pending or arriving now) takes effect at
  // the first frame boundary: either the last sample of the running frame or
  // a cycle sitting at slot 0 with no sample accepted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    inv_frame_d = inv_frame_q;
    accept      = 1'b0;
    last        = 1'b0;
    stop_req    = stop_pend_q | bus.stop;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RUN;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
        end
      end
      RUN: begin
        accept = bus.in_valid;
        last   = accept && (cnt_q == LAST_IDX);
        if (bus.stop) stop_pend_d = 1'b1;
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) inv_frame_d = bus.inverse_i;
        end
        if ((last || (!accept && cnt_q == '0)) && stop_req) begin
          state_d     = DRAIN;
          stop_pend_d = 1'b0;
        end
      end
      DRAIN: begin
        if (pipe_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      inv_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      inv_frame_q <= inv_frame_d;
    end
  end

  // inv_frame_q was captured on slot 0, which always precedes the last slot.
  fft_ctrl_stage_pipe #(.LOG2N(LOG2N)) u_pipe (
    .clk           (clk),
    .reset         (reset),
    .load_i        (last),
    .load_inv_i    (inv_frame_q),
    .en_stage_o    (bus.en_stage),
    .inv_stage_o   (bus.inv_stage),
    .out_valid_o   (bus.out_valid),
    .out_inverse_o (bus.out_inverse),
    .pipe_empty_o  (pipe_empty)
  );

  assign bus.en_s2p     = accept;
  assign bus.sample_idx = cnt_q;
  assign bus.frame_last = last;
  assign bus.busy       = (state_q != IDLE);
  assign bus.dbg_state  = state_q;

`ifdef FFT_CTRL_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q;

  // Completed-frame counter; wraps, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt_q <= '0;
    else if (bus.out_valid) frame_cnt_q <= frame_cnt_q + 1'b1;
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule
